// File: rtl/sys_bus_hs.sv
// Handshaked single-master system bus: registers a CPU request, drives one-hot
// slave select until ack or timeout, then returns a one-cycle response.
module sys_bus_hs #(
  parameter int unsigned N_SLV    = 4,
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 32,
  parameter int unsigned SEL_LSB  = 28,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_wen,
  input  logic [AW-1:0]       cpu_addr,
  input  logic [DW-1:0]       cpu_wdata,
  input  logic [DW/8-1:0]     cpu_wstrb,
  output logic                cpu_ready,
  output logic [DW-1:0]       cpu_rdata,
  output logic                cpu_err,
  output logic [N_SLV-1:0]    slv_req,
  output logic                slv_wen,
  output logic [AW-1:0]       slv_addr,
  output logic [DW-1:0]       slv_wdata,
  output logic [DW/8-1:0]     slv_wstrb,
  input  logic [N_SLV*DW-1:0] slv_rdata,
  input  logic [N_SLV-1:0]    slv_ack,
  output logic                bus_busy,
  output logic [7:0]          err_cnt
);

  localparam int unsigned HW      = AW - SEL_LSB;
  localparam int unsigned SW      = DW / 8;
  localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [DW-1:0] ERR_D = DW'(ERR_DATA);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [HW-1:0]     r_idx, w_idx_nxt;
  logic [TW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_err, w_err_nxt;
  logic [DW-1:0]     r_cap_data, w_cap_data_nxt;
  logic [N_SLV-1:0]  r_slv_req, w_slv_req_nxt;
  logic              r_slv_wen, w_slv_wen_nxt;
  logic [AW-1:0]     r_slv_addr, w_slv_addr_nxt;
  logic [DW-1:0]     r_slv_wdata, w_slv_wdata_nxt;
  logic [SW-1:0]     r_slv_wstrb, w_slv_wstrb_nxt;
  logic              r_cpu_ready, w_cpu_ready_nxt;
  logic [DW-1:0]     r_cpu_rdata, w_cpu_rdata_nxt;
  logic              r_cpu_err, w_cpu_err_nxt;
  logic              r_busy, w_busy_nxt;
  logic [7:0]        r_err_cnt, w_err_cnt_nxt;

  logic [HW-1:0]     w_cpu_idx;
  logic              w_mapped;
  logic [N_SLV-1:0]  w_dec_req;
  logic [DW-1:0]     w_sel_rdata;
  logic              w_sel_ack;

  assign w_cpu_idx = cpu_addr[AW-1:SEL_LSB];
  assign w_mapped  = 32'(w_cpu_idx) < N_SLV;

  // Address-head decode and mux of the selected slave's ack/read data
  always_comb begin
    w_sel_rdata = '0;
    w_sel_ack   = 1'b0;
    w_dec_req   = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (r_idx == HW'(i)) begin
        w_sel_rdata = slv_rdata[i*DW +: DW];
        w_sel_ack   = slv_ack[i];
      end
      if (w_cpu_idx == HW'(i)) w_dec_req[i] = 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_err_nxt       = r_err;
    w_cap_data_nxt  = r_cap_data;
    w_slv_req_nxt   = r_slv_req;
    w_slv_wen_nxt   = r_slv_wen;
    w_slv_addr_nxt  = r_slv_addr;
    w_slv_wdata_nxt = r_slv_wdata;
    w_slv_wstrb_nxt = r_slv_wstrb;
    w_cpu_ready_nxt = 1'b0;
    w_cpu_rdata_nxt = '0;
    w_cpu_err_nxt   = 1'b0;
    w_err_cnt_nxt   = r_err_cnt;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          w_slv_wen_nxt   = cpu_wen;
          w_slv_addr_nxt  = cpu_addr;
          w_slv_wdata_nxt = cpu_wdata;
          w_slv_wstrb_nxt = cpu_wstrb;
          w_idx_nxt       = w_cpu_idx;
          if (w_mapped) begin
            w_slv_req_nxt = w_dec_req;
            w_cnt_nxt     = '0;
            w_state_nxt   = S_ACCESS;
          end else begin
            w_err_nxt      = 1'b1;
            w_cap_data_nxt = cpu_wen ? '0 : ERR_D;
            w_state_nxt    = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        // Ack wins over a coinciding timeout edge
        if (w_sel_ack) begin
          w_cap_data_nxt = r_slv_wen ? '0 : w_sel_rdata;
          w_err_nxt      = 1'b0;
          w_slv_req_nxt  = '0;
          w_state_nxt    = S_RESP;
        end else if (TIMEOUT != 0 && r_cnt == TW'(TO_LAST)) begin
          w_cap_data_nxt = r_slv_wen ? '0 : ERR_D;
          w_err_nxt      = 1'b1;
          w_slv_req_nxt  = '0;
          w_state_nxt    = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + TW'(1);
        end
      end
      S_RESP: begin
        w_cpu_ready_nxt = 1'b1;
        w_cpu_rdata_nxt = r_cap_data;
        w_cpu_err_nxt   = r_err;
        if (r_err && r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_cap_data  <= '0;
      r_slv_req   <= '0;
      r_slv_wen   <= 1'b0;
      r_slv_addr  <= '0;
      r_slv_wdata <= '0;
      r_slv_wstrb <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err       <= w_err_nxt;
      r_cap_data  <= w_cap_data_nxt;
      r_slv_req   <= w_slv_req_nxt;
      r_slv_wen   <= w_slv_wen_nxt;
      r_slv_addr  <= w_slv_addr_nxt;
      r_slv_wdata <= w_slv_wdata_nxt;
      r_slv_wstrb <= w_slv_wstrb_nxt;
      r_cpu_ready <= w_cpu_ready_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_cpu_err   <= w_cpu_err_nxt;
      r_busy      <= w_busy_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign cpu_ready = r_cpu_ready;
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_err   = r_cpu_err;
  assign slv_req   = r_slv_req;
  assign slv_wen   = r_slv_wen;
  assign slv_addr  = r_slv_addr;
  assign slv_wdata = r_slv_wdata;
  assign slv_wstrb = r_slv_wstrb;
  assign bus_busy  = r_busy;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_sys_bus_hs.sv
// Directed bench for sys_bus_hs (4 slaves, 32-bit, TIMEOUT=8): vector table of
// transactions plus hand-written saturation and asynchronous-reset sequences.
module tb_sys_bus_hs;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_wen;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [3:0]   cpu_wstrb;
  logic         cpu_ready, cpu_err;
  logic [31:0]  cpu_rdata;
  logic [3:0]   slv_req;
  logic         slv_wen;
  logic [31:0]  slv_addr, slv_wdata;
  logic [3:0]   slv_wstrb;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_ack;
  logic         bus_busy;
  logic [7:0]   err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  sys_bus_hs #(.N_SLV(4), .DW(32), .AW(32), .SEL_LSB(28), .TIMEOUT(8),
               .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .slv_req(slv_req), .slv_wen(slv_wen), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
    .slv_rdata(slv_rdata), .slv_ack(slv_ack),
    .bus_busy(bus_busy), .err_cnt(err_cnt)
  );

  // delay = wait cycles before ack; 255 means the target never acks
  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          slave;
    int          delay;
    logic [31:0] ack_data;
    logic [3:0]  stray;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_req;
    int          exp_cycles;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int n, reqc;
    logic [3:0] req_or;
    logic stable, done;
    for (int i = 0; i < 4; i++)
      slv_rdata[i*32 +: 32] = (i == v.slave) ? v.ack_data : 32'hA0A0_0000 + 32'(i);
    @(negedge clk);
    cpu_req = 1'b1; cpu_wen = v.wen; cpu_addr = v.addr;
    cpu_wdata = v.wdata; cpu_wstrb = v.wstrb;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = 32'h7777_7777; cpu_wdata = ~v.wdata;
    cpu_wstrb = ~v.wstrb; cpu_wen = ~v.wen;
    check("busy_after_accept", 32'(bus_busy), 32'd1);
    n = 0; reqc = 0; req_or = '0; stable = 1'b1; done = 1'b0;
    while (!done && n < 40) begin
      if (slv_req != 4'b0) begin
        reqc++;
        req_or |= slv_req;
        if (slv_wen !== v.wen || slv_addr !== v.addr ||
            slv_wdata !== v.wdata || slv_wstrb !== v.wstrb) stable = 1'b0;
      end
      if (cpu_ready === 1'b1) begin
        done = 1'b1;
      end else begin
        slv_ack = v.stray;
        if (v.slave >= 0 && v.slave < 4 && v.delay != 255)
          if (slv_req[v.slave] && reqc == v.delay + 1) slv_ack[v.slave] = 1'b1;
        @(posedge clk); n++; #1;
      end
    end
    slv_ack = '0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: no cpu_ready within 40 cycles of addr 0x%08h", v.addr);
    end else begin
      if (v.exp_err) exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      check("latency",     32'(n),        32'(v.exp_lat));
      check("rdata",       cpu_rdata,     v.exp_rdata);
      check("err",         32'(cpu_err),  32'(v.exp_err));
      check("req_cycles",  32'(reqc),     32'(v.exp_cycles));
      check("req_onehot",  32'(req_or),   32'(v.exp_req));
      check("slv_stable",  32'(stable),   32'd1);
      check("busy_at_rdy", 32'(bus_busy), 32'd0);
      check("err_cnt",     32'(err_cnt),  32'(exp_cnt));
      @(posedge clk); #1;
      check("ready_drop",  32'(cpu_ready), 32'd0);
      check("rdata_clear", cpu_rdata,      32'd0);
      check("err_clear",   32'(cpu_err),   32'd0);
    end
  endtask

  vec_t vecs[8];
  vec_t unm;
  logic seen_ready;

  initial begin
    vecs[0] = '{1'b0, 32'h1000_0004, 32'h0,         4'h0, 1, 0,   32'h1234_5678, 4'b0000,
                2, 32'h1234_5678, 1'b0, 4'b0010, 1};
    vecs[1] = '{1'b1, 32'h2000_0000, 32'h0000_00A5, 4'h1, 2, 3,   32'h5555_5555, 4'b0000,
                5, 32'h0,         1'b0, 4'b0100, 4};
    vecs[2] = '{1'b0, 32'h5000_0000, 32'h0,         4'h0, -1, 0,  32'h0,         4'b0000,
                1, 32'hDEAD_BEEF, 1'b1, 4'b0000, 0};
    vecs[3] = '{1'b0, 32'h3000_0010, 32'h0,         4'h0, 3, 255, 32'h0,         4'b0001,
                9, 32'hDEAD_BEEF, 1'b1, 4'b1000, 8};
    vecs[4] = '{1'b0, 32'h3000_0020, 32'h0,         4'h0, 3, 7,   32'hCAFE_F00D, 4'b0000,
                9, 32'hCAFE_F00D, 1'b0, 4'b1000, 8};
    vecs[5] = '{1'b1, 32'h0000_0100, 32'h1357_9BDF, 4'hF, 0, 255, 32'h0,         4'b0010,
                9, 32'h0,         1'b1, 4'b0001, 8};
    vecs[6] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 1,   32'h0BAD_F00D, 4'b1110,
                3, 32'h0BAD_F00D, 1'b0, 4'b0001, 2};
    vecs[7] = '{1'b1, 32'hF000_0000, 32'hFFFF_0000, 4'hC, -1, 0,  32'h0,         4'b0000,
                1, 32'h0,         1'b1, 4'b0000, 0};
    unm     = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, -1, 0,  32'h0,         4'b0000,
                1, 32'hDEAD_BEEF, 1'b1, 4'b0000, 0};

    rst = 1'b1; cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; cpu_wstrb = '0; slv_rdata = '0; slv_ack = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",   32'(cpu_ready), 32'd0);
    check("rst_req",     32'(slv_req),   32'd0);
    check("rst_busy",    32'(bus_busy),  32'd0);
    check("rst_err_cnt", 32'(err_cnt),   32'd0);
    check("rst_rdata",   cpu_rdata,      32'd0);
    check("rst_addr",    slv_addr,       32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // err_cnt saturation over 256 further error responses
    for (int i = 0; i < 256; i++) run_txn(unm);
    check("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Asynchronous reset in the middle of an unacknowledged access
    @(negedge clk);
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h2000_0000;
    @(posedge clk); #1; cpu_req = 1'b0;
    check("pre_rst_req", 32'(slv_req), 32'b0100);
    @(posedge clk); @(posedge clk);
    #2; rst = 1'b1;
    #1;
    check("arst_req",     32'(slv_req),   32'd0);
    check("arst_busy",    32'(bus_busy),  32'd0);
    check("arst_ready",   32'(cpu_ready), 32'd0);
    check("arst_err_cnt", 32'(err_cnt),   32'd0);
    #1; rst = 1'b0;
    exp_cnt = 0;
    seen_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (cpu_ready !== 1'b0 || slv_req !== 4'b0) seen_ready = 1'b1;
    end
    check("no_resp_after_rst", 32'(seen_ready), 32'd0);
    run_txn(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sys_bus_hs.md
Name: sys_bus_hs

Overview:
- Parametrised, handshaked successor to the single-master system bus decoder. It connects one CPU data port to N_SLV memory-mapped slaves.
- Each transaction is registered: request latched, slave selected via address-head decode, slave held until ack, then a single-cycle response to the CPU.
- Adds wait-state support, a per-access timeout, error responses for unmapped or hung slaves, and a saturating error counter.

Parameters:
- N_SLV, 4, number of slave ports; slave index = address head.
- DW, 32, data width (multiple of 8).
- AW, 32, address width.
- SEL_LSB, 28, LSB of the address-head field; field is cpu_addr[AW-1:SEL_LSB].
- TIMEOUT, 255, max cycles slv_req may wait for ack; 0 disables timeout.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error (truncated/zero-extended to DW).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- cpu_req  in  1  CPU request strobe, sampled only in IDLE
- cpu_wen  in  1  1 = write, 0 = read
- cpu_addr  in  AW  byte address
- cpu_wdata  in  DW  write data
- cpu_wstrb  in  DW/8  byte enables for writes
- cpu_ready  out  1  one-cycle response strobe
- cpu_rdata  out  DW  read data, valid while cpu_ready=1
- cpu_err  out  1  error flag, valid while cpu_ready=1
- slv_req  out  N_SLV  one-hot slave select/request
- slv_wen  out  1  latched write enable, broadcast
- slv_addr  out  AW  latched address, broadcast
- slv_wdata  out  DW  latched write data, broadcast
- slv_wstrb  out  DW/8  latched strobes, broadcast
- slv_rdata  in  N_SLV*DW  packed slave read data; slave i at [i*DW +: DW]
- slv_ack  in  N_SLV  per-slave completion strobe
- bus_busy  out  1  high whenever state != IDLE
- err_cnt  out  8  saturating count of error responses

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0, including slv_req, cpu_ready, cpu_err, cpu_rdata, slv_* and err_cnt. An in-flight access is abandoned with no response.
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If cpu_req=0, stay in IDLE.
  - If cpu_req=1: latch wen/addr/wdata/wstrb into slv_* and compute idx = cpu_addr[AW-1:SEL_LSB].
  - If idx < N_SLV: next cycle slv_req[idx]=1, timeout counter=0, go to ACCESS.
  - Else (unmapped): go to RESP with err=1 and no slv_req assertion.
- ACCESS:
  - slv_req[idx] and slv_* stay stable.
  - Only slv_ack[idx] is honoured; acks on other bits are ignored.
  - On slv_ack[idx]=1:
    - Read: capture slv_rdata slice idx.
    - Write: captured data = 0.
    - err=0; drop slv_req next cycle; go to RESP.
  - Without ack, the counter increments each cycle. If TIMEOUT!=0 and counter==TIMEOUT-1 with no ack this cycle: err=1, drop slv_req, go to RESP.
  - This gives exactly TIMEOUT cycles of slv_req high before the error.
  - If ack and the timeout edge coincide, ack wins (err=0).
- RESP:
  - cpu_ready=1 for exactly one cycle.
  - cpu_rdata = captured data (ERR_DATA if err and read; 0 if err and write); cpu_err = err.
  - Next state IDLE. cpu_req is ignored during RESP.
  - cpu_rdata/cpu_err return to 0 when cpu_ready falls.
- Latency:
  - Zero-wait slave (ack in first slv_req cycle): cpu_ready 2 cycles after the accepting edge.
  - Each wait cycle adds 1.
  - Unmapped access: cpu_ready 1 cycle after acceptance.
  - Back-to-back throughput: one transaction per 3 cycles minimum.
- err_cnt: +1 on every RESP cycle with err=1; saturates at 255 and never wraps.
- slv_wen/addr/wdata/wstrb hold their last latched values between transactions. Slaves must qualify on slv_req.
- The CPU must hold request fields stable only on the accepting cycle.

Test Plan:
- Read addr 0x1000_0004, slave1 acks in the first cycle with 0x1234_5678 → slv_req=4'b0010 for 1 cycle; cpu_ready at +2 with rdata 0x1234_5678, err=0.
- Write 0x2000_0000, data 0xA5, wstrb 4'b0001, slave2 acks after 3 wait cycles → slv_wen=1, slv_wdata=0xA5 stable throughout; cpu_ready at +5, rdata=0, err=0.
- Read 0x5000_0000 (idx 5 ≥ N_SLV) → no slv_req; cpu_ready at +1, rdata=0xDEAD_BEEF, err=1, err_cnt=1.
- TIMEOUT=8, read slave3 never acks; stray slv_ack[0] pulses → slv_req[3] high exactly 8 cycles; cpu_ready with err=1, rdata=0xDEAD_BEEF.
- Ack on the same cycle as the timeout edge → err=0, data returned. 256 unmapped accesses → err_cnt stays 255.
- rst pulsed mid-ACCESS (asynchronously, between edges) → slv_req, bus_busy and cpu_ready drop immediately; no cpu_ready afterwards; a next read completes normally.
